// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// ------------
// 8N1 UART receiver. It samples LSB first at the middle of each bit.
// Bit timing comes from a counter of CLKS_PER_BIT clocks per bit.
// The received byte feeds the hex-to-digit converter downstream:
//   data_out   -> hex_in
//   data_valid -> en
//
// Optional build macro UART_RX_PARITY_EN adds one even-parity bit between
// the data bits and the stop bit.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (legal 4..65535)
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   rx          asynchronous serial input, idle high
//   data_out    last correctly framed byte, held until the next good byte
//   data_valid  one-cycle pulse when data_out updates
//   frame_err   one-cycle pulse when the stop bit samples low
//   parity_err  one-cycle pulse on parity mismatch (constant 0 without parity)
//   busy        high whenever the receiver is not idle
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  // Armed only after rx_s has been seen high in IDLE. A held-low line
  // (break) therefore cannot start a new frame after a framing error.
  logic             armed_q, armed_d;
  logic             par_mismatch;
`ifdef UART_RX_PARITY_EN
  logic             par_bit_q, par_bit_d;
  logic             parity_err_q, parity_err_d;
`endif

`ifdef UART_RX_PARITY_EN
  // Even parity: the received parity bit must equal the XOR of the data.
  assign par_mismatch = (^shift_q) != par_bit_q;
`else
  assign par_mismatch = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    armed_d      = armed_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = S_START;
          armed_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            // The start bit was not low at mid-bit: treat it as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_bit_d = rx_s_q;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          // Return to IDLE at mid-stop-bit so that a back-to-back start
          // bit is still caught.
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
          end else if (par_mismatch) begin
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b1;
`endif
          end else begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      armed_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      armed_q      <= armed_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
